lsu_axi_gen2: RTL and testbench
===============================

Name: lsu_axi_gen2

Overview:
Second-generation load/store unit. It bridges the EXU memory request port to one AXI4 master port and is parametrised in data width, ID width and address width. Compared with the first-generation LSU it adds:
- concurrent AW/W issue;
- correct zero or sign extension driven by the request's unsigned flag;
- misalignment trapping without issuing a bus access;
- a registered response that carries an error code.

It sits between the EXU and the SoC crossbar and allows one transaction in flight.

Parameters:
DATA_W, 32, AXI data width in bits; legal values 32 or 64.
ADDR_W, 32, address width in bits.
ID_W, 4, width of the AXI ID fields.
NARROW_TAG, 8'h20, value of addr[ADDR_W-1:ADDR_W-8] that marks a narrow region; such a region returns read data right-aligned in lane 0.

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
req_size  in  3  log2 of access bytes (0 to log2(DATA_W/8))
req_unsigned  in  1  zero-extend the load result
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  2  0 ok, 1 misaligned, 2 bus error (resp != OKAY), 3 ID mismatch
AXI signals  in/out  per AXI4  aw{valid,ready,addr,id,len,size,burst}, w{valid,ready,data,strb,last}, b{valid,ready,resp,id}, ar{valid,ready,addr,id,len,size,burst}, r{valid,ready,data,resp,id,last}

Behaviour:
- Reset state:
  - All valid and ready outputs are 0, except req_ready = 1.
  - resp_rdata = 0, resp_err = 0.
  - The ID counter resets to 0.
  - State is IDLE.
  - If reset is asserted mid-transaction, the FSM drops to IDLE immediately; any outstanding AXI handshake is abandoned.
- Fixed AXI fields: len = 0, burst = INCR (2'b01), wlast = 1. axsize = the saved req_size.
- IDLE:
  - req_ready = 1.
  - On req_valid, the LSU latches addr, wdata, size, unsigned, wen and cur_id = id_cnt + 1. id_cnt is then incremented and wraps modulo 2^ID_W.
  - Misalignment check: addr mod 2^size != 0, or size > log2(DATA_W/8). If misaligned, go to RESP with err = 1 and issue no AXI access.
  - Otherwise go to WRITE if wen = 1, else to RADDR.
- WRITE:
  - awvalid and wvalid are both asserted in the first cycle.
  - Each is deasserted individually once its handshake completes.
  - When both handshakes have completed (same cycle or different cycles), go to WRESP.
  - wstrb = ((1 << 2^size) - 1) << addr offset within the data lane.
  - wdata = saved wdata shifted left by 8 × offset.
- WRESP:
  - bready = 1.
  - On bvalid, go to RESP. err = 3 if bid != cur_id, else 2 if bresp != 0, else 0.
- RADDR: arvalid = 1; on arready, go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid, capture the data, go to RESP and set err with the same rule as WRESP, using rid and rresp.
  - Lane extraction: shift right by 8 × offset, except in the narrow region, where the shift is 0.
  - Extension: mask to 2^size bytes. Sign-extend from the MSB of the accessed size unless unsigned = 1 or size equals the full data width.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_rdata and resp_err registered.
  - Next state is IDLE.
  - req_ready is 0 throughout, so back-to-back request latency is 1 cycle of RESP plus 1 IDLE cycle.
- Latency with zero-wait AXI:
  - Load: IDLE → RADDR → RDATA → RESP, so resp_valid arrives 4 cycles after acceptance.
  - Store: 4 cycles.
  - Misaligned: 2 cycles.
- AXI stability: valid, once asserted, is held and address/data do not change until the handshake. Outputs depend only on registered state, with no combinational path from any ready input to a valid output.

Test Plan:
1. Load, DATA_W = 32, addr 0x8000_0003, size 0, signed, rdata 0x8000_0000: arsize = 0; resp_rdata = 0xFFFF_FF80; resp_err = 0; resp_valid 4 cycles after acceptance.
2. Same access as scenario 1 with req_unsigned = 1 → resp_rdata = 0x0000_0080. Narrow-region addr 0x2000_0001 with rdata 0x0000_00AB, unsigned → 0x0000_00AB.
3. Store: addr 0x8000_0002, size 1, wdata 0x1234; awready delayed 3 cycles, wready immediate → wstrb = 4'b1100, wdata = 0x1234_0000; wvalid drops after 1 cycle; resp_valid follows the single bvalid.
4. lw at 0x8000_0002 → no arvalid ever; resp_err = 1 two cycles after acceptance; resp_rdata = 0.
5. bresp = 2'b10 → resp_err = 2. rid = cur_id ^ 1 → resp_err = 3. Over 17 consecutive requests the ID wraps from 0xF to 0x0 and then 0x1.
6. Assert reset while in RDATA → next cycle req_ready = 1 and rready = 0. A fresh load then completes normally with id = 1.

Source files
------------

// File: rtl/lsu_axi_gen2.sv
// Load/store unit bridging the EXU memory request port to a single AXI4 master.
// One transaction in flight; misaligned requests trap without touching the bus.
module lsu_axi_gen2 #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter logic [7:0]  NARROW_TAG = 8'h20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [2:0]          req_size,
  input  logic                req_unsigned,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [ID_W-1:0]     awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [ID_W-1:0]     arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic [ID_W-1:0]     rid,
  input  logic                rlast
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;

  state_t              state, state_nx;
  logic [ID_W-1:0]     id_cnt, cur_id;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [2:0]          size_q;
  logic                uns_q;
  logic                aw_done, w_done;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          err_q;

  logic                mis_in;
  logic [STRB_W-1:0]   strb_in;
  logic [DATA_W-1:0]   wdata_in;
  int unsigned         off_in, nbytes_in;
  logic [DATA_W-1:0]   lane, ext_data;
  int unsigned         off_q, nbits_q;
  logic                sign_bit, sext;
  logic [1:0]          b_code, r_code;
  logic                unused_rlast;

  assign unused_rlast = rlast;

  function automatic logic [1:0] resp_code(input logic [ID_W-1:0] got_id,
                                           input logic [ID_W-1:0] want_id,
                                           input logic [1:0] axi_resp);
    if (got_id != want_id) return 2'd3;
    if (axi_resp != 2'b00) return 2'd2;
    return 2'd0;
  endfunction

  assign b_code = resp_code(bid, cur_id, bresp);
  assign r_code = resp_code(rid, cur_id, rresp);

  // Request decode: alignment check, byte strobes and lane-shifted store data.
  always_comb begin
    off_in    = 32'(req_addr[OFF_W-1:0]);
    nbytes_in = 32'd1 << req_size;
    mis_in    = (32'(req_size) > OFF_W);
    for (int unsigned i = 0; i < OFF_W; i++) begin
      if (i < 32'(req_size) && req_addr[i]) mis_in = 1'b1;
    end
    strb_in = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (i >= off_in && i < off_in + nbytes_in) strb_in[i] = 1'b1;
    end
    wdata_in = req_wdata << (8 * off_in);
  end

  // Load result: lane extraction (none in the narrow region), masking, extension.
  always_comb begin
    off_q    = 32'(addr_q[OFF_W-1:0]);
    nbits_q  = 32'd8 << size_q;
    lane     = (addr_q[ADDR_W-1 -: 8] == NARROW_TAG) ? rdata : (rdata >> (8 * off_q));
    sext     = !uns_q && (32'(size_q) != OFF_W);
    sign_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i == nbits_q - 1) sign_bit = lane[i];
    end
    ext_data = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ext_data[i] = (i < nbits_q) ? lane[i] : (sext & sign_bit);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (req_valid) state_nx = mis_in ? RESP : (req_wen ? WRITE : RADDR);
      WRITE: if ((aw_done || awready) && (w_done || wready)) state_nx = WRESP;
      WRESP: if (bvalid) state_nx = RESP;
      RADDR: if (arready) state_nx = RDATA;
      RDATA: if (rvalid) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, request capture, handshake tracking and registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      id_cnt  <= '0;
      cur_id  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= wdata_in;
          strb_q  <= strb_in;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          id_cnt  <= id_cnt + ID_W'(1);
          cur_id  <= id_cnt + ID_W'(1);
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (mis_in) begin
            rdata_q <= '0;
            err_q   <= 2'd1;
          end
        end
        WRITE: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready) w_done <= 1'b1;
        end
        WRESP: if (bvalid) begin
          rdata_q <= '0;
          err_q   <= b_code;
        end
        RDATA: if (rvalid) begin
          rdata_q <= (r_code == 2'd0) ? ext_data : '0;
          err_q   <= r_code;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign awvalid = (state == WRITE) && !aw_done;
  assign wvalid  = (state == WRITE) && !w_done;
  assign bready  = (state == WRESP);
  assign arvalid = (state == RADDR);
  assign rready  = (state == RDATA);

  assign awaddr  = addr_q;
  assign awid    = cur_id;
  assign awlen   = '0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = strb_q;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign arid    = cur_id;
  assign arlen   = '0;
  assign arsize  = size_q;
  assign arburst = 2'b01;

endmodule

// File: tb/tb_lsu_axi_gen2.sv
// Bench for lsu_axi_gen2: directed requests against a configurable AXI slave,
// with an arithmetic reference model and a per-cycle compare process.
module tb_lsu_axi_gen2;

  logic        clock, reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, bid, rid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  lsu_axi_gen2 #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .NARROW_TAG(8'h20)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave configuration for the current transaction.
  int          s_ard, s_rd, s_awd, s_wd, s_bd;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  bit          s_flip;

  // Model expectations for the transaction in flight.
  bit          exp_pending = 0;
  bit          e_wen, e_mis;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_id, e_strb;
  logic [2:0]  e_size;
  logic [1:0]  e_err;
  int          e_acc, e_edge, e_nar, e_naw, e_nw;
  int          m_id = 0;
  int          n_ar, n_aw, n_w, last_lat;
  logic [3:0]  last_arid;
  logic [2:0]  last_arsize;

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference model, from the access rules expressed as plain arithmetic.
  function automatic bit m_mis(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] s,
                                         input bit u, input logic [31:0] d);
    int unsigned nb  = 32'd1 << s;
    int unsigned off = a % 4;
    logic [63:0] v;
    v = (a[31:24] == 8'h20) ? 64'(d) : 64'(d >> (8 * off));
    if (nb < 4) begin
      v = v % (64'd1 << (8 * nb));
      if (!u && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [2:0] s);
    logic [7:0] t;
    t = 8'((32'd1 << (32'd1 << s)) - 1) << (a % 4);
    return t[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] t;
    t = 64'(d) << (8 * (a % 4));
    return t[31:0];
  endfunction

  // AXI slave: ready/valid after a programmed number of wait cycles.
  initial begin
    int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
    logic [3:0] s_arid = 0, s_awid = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(posedge clock); #1;
      if (arvalid) begin ar_n++; s_arid = arid; arready = (ar_n > s_ard); end
      else begin ar_n = 0; arready = 0; end
      if (awvalid) begin aw_n++; s_awid = awid; awready = (aw_n > s_awd); end
      else begin aw_n = 0; awready = 0; end
      if (wvalid) begin w_n++; wready = (w_n > s_wd); end
      else begin w_n = 0; wready = 0; end
      if (rready) begin
        r_n++; rvalid = (r_n > s_rd); rdata = s_rdata; rresp = s_resp; rlast = 1;
        rid = s_flip ? (s_arid ^ 4'h1) : s_arid;
      end else begin r_n = 0; rvalid = 0; end
      if (bready) begin
        b_n++; bvalid = (b_n > s_bd); bresp = s_resp;
        bid = s_flip ? (s_awid ^ 4'h1) : s_awid;
      end else begin b_n = 0; bvalid = 0; end
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clock) begin
    if (!reset) begin
      chk("req_ready", req_ready, !exp_pending);
      if (arvalid) begin
        n_ar++; last_arid = arid; last_arsize = arsize;
        chk("ar_fields", {araddr, arid, arsize, arlen, arburst}, {e_addr, e_id, e_size, 8'h00, 2'b01});
      end
      if (awvalid) begin
        n_aw++;
        chk("aw_fields", {awaddr, awid, awsize, awlen, awburst}, {e_addr, e_id, e_size, 8'h00, 2'b01});
      end
      if (wvalid) begin
        n_w++;
        chk("w_fields", {wdata, wstrb, wlast}, {e_wdata, e_strb, 1'b1});
      end
      if (resp_valid) begin
        if (!exp_pending) begin
          checks++; errors++;
          $display("FAIL unexpected_resp got resp_valid=1 want 0");
        end else begin
          last_lat = cyc - e_acc;
          chk("resp_rdata", resp_rdata, e_rdata);
          chk("resp_err", resp_err, e_err);
          chk("resp_cycle", cyc, e_edge);
          chk("ar_cycles", n_ar, e_nar);
          chk("aw_cycles", n_aw, e_naw);
          chk("w_cycles", n_w, e_nw);
          exp_pending = 0;
        end
      end else if (exp_pending && cyc > e_edge) begin
        checks++; errors++;
        $display("FAIL resp_missing got none want resp at cycle %0d", e_edge);
        exp_pending = 0;
      end
    end
  end

  // Issue one request; hand-computed h_* values pin the model before use.
  task automatic run(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] size, input bit uns, input logic [31:0] srd,
                     input logic [1:0] sresp, input bit flip,
                     input int ard, input int rd, input int awd, input int wdl, input int bd,
                     input logic [31:0] h_rdata, input logic [1:0] h_err,
                     input logic [3:0] h_strb, input logic [31:0] h_wdata);
    int lat;
    s_ard = ard; s_rd = rd; s_awd = awd; s_wd = wdl; s_bd = bd;
    s_rdata = srd; s_resp = sresp; s_flip = flip;
    e_wen = wen; e_addr = addr; e_size = size;
    e_mis = m_mis(addr, size);
    e_strb = e_mis ? 4'h0 : m_strb(addr, size);
    e_wdata = m_wdata(addr, wd);
    if (e_mis) e_err = 2'd1;
    else if (flip) e_err = 2'd3;
    else if (sresp != 2'b00) e_err = 2'd2;
    else e_err = 2'd0;
    e_rdata = (e_mis || wen || e_err != 0) ? 32'h0 : m_load(addr, size, uns, srd);
    if (e_mis) lat = 0;
    else if (wen) lat = 2 + ((awd > wdl) ? awd : wdl) + bd;
    else lat = 2 + ard + rd;
    e_nar = (!e_mis && !wen) ? ard + 1 : 0;
    e_naw = (!e_mis && wen) ? awd + 1 : 0;
    e_nw  = (!e_mis && wen) ? wdl + 1 : 0;
    chk("model_pin_resp", {e_rdata, e_err}, {h_rdata, h_err});
    if (wen && !e_mis) chk("model_pin_store", {e_strb, e_wdata}, {h_strb, h_wdata});
    @(posedge clock); #1;
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = size; req_unsigned = uns;
    @(posedge clock); #1;
    req_valid = 0;
    m_id = (m_id + 1) % 16;
    e_id = 4'(m_id);
    e_acc = cyc; e_edge = cyc + lat;
    n_ar = 0; n_aw = 0; n_w = 0;
    exp_pending = 1;
    for (int k = 0; k < 60 && exp_pending; k++) @(posedge clock);
    if (exp_pending) begin
      checks++; errors++;
      $display("FAIL run_timeout got pending want done");
      exp_pending = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    m_id = 0;
    exp_pending = 0;
  endtask

  logic [3:0] idw [3] = '{4'hF, 4'h0, 4'h1};

  initial begin
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    s_ard = 0; s_rd = 0; s_awd = 0; s_wd = 0; s_bd = 0; s_rdata = 0; s_resp = 0; s_flip = 0;
    do_reset();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {resp_valid, awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_resp", {resp_rdata, resp_err}, 0);

    // Loads: sign/zero extension, lane offsets, narrow region, stalls.
    run(0, 32'h8000_0003, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 0, 0);
    chk("t1_arsize", last_arsize, 0);
    chk("t1_latency", last_lat + 2, 4);
    run(0, 32'h8000_0003, 0, 0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0080, 0, 0, 0);
    run(0, 32'h2000_0001, 0, 0, 1, 32'h0000_00AB, 0, 0, 0, 0, 0, 0, 0, 32'h0000_00AB, 0, 0, 0);
    run(0, 32'h8000_0001, 0, 0, 1, 32'h0000_00AB, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
    run(0, 32'h8000_0002, 0, 1, 0, 32'hBEEF_0000, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_BEEF, 0, 0, 0);
    run(0, 32'h8000_0004, 0, 2, 0, 32'h8765_4321, 0, 0, 0, 0, 0, 0, 0, 32'h8765_4321, 0, 0, 0);
    run(0, 32'h8000_0001, 0, 0, 0, 32'h0000_7F00, 0, 0, 2, 1, 0, 0, 0, 32'h0000_007F, 0, 0, 0);

    // Stores: AW/W completing in different cycles, strobes and lane shift.
    run(1, 32'h8000_0002, 32'h0000_1234, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 4'b1100, 32'h1234_0000);
    chk("t3_latency", last_lat + 2, 7);
    run(1, 32'h8000_0004, 32'hDEAD_BEEF, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 4'b1111, 32'hDEAD_BEEF);
    run(1, 32'h8000_0003, 32'h0000_00A5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 32'hA500_0000);

    // Misaligned: trapped without bus activity.
    run(0, 32'h8000_0002, 0, 2, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    chk("t4_latency", last_lat + 2, 2);
    run(0, 32'h8000_0000, 0, 3, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    run(1, 32'h8000_0001, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);

    // Bus error and ID mismatch.
    run(1, 32'h8000_0008, 32'h1, 2, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 32'h0, 2, 4'b1111, 32'h1);
    run(0, 32'h8000_0008, 0, 2, 0, 32'h1234_5678, 0, 1, 0, 0, 0, 0, 0, 32'h0, 3, 0, 0);

    // ID wrap over 17 consecutive requests from reset.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run(0, 32'h8000_0000 + 32'(4 * i), 0, 2, 0, 32'(i), 0, 0, 0, 0, 0, 0, 0, 32'(i), 0, 0, 0);
      if (i >= 14) chk("id_wrap", last_arid, idw[i-14]);
    end

    // Reset while waiting in RDATA abandons the transaction.
    s_ard = 0; s_rd = 8; s_rdata = 32'h0; s_resp = 0; s_flip = 0;
    e_wen = 0; e_mis = 0; e_addr = 32'h8000_0010; e_size = 3'd2;
    @(posedge clock); #1;
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0010; req_size = 3'd2; req_unsigned = 0;
    @(posedge clock); #1;
    req_valid = 0;
    m_id = (m_id + 1) % 16; e_id = 4'(m_id);
    e_acc = cyc; e_edge = cyc + 20; n_ar = 0; n_aw = 0; n_w = 0;
    exp_pending = 1;
    @(posedge clock); #1;
    chk("abort_in_rdata", rready, 1);
    reset = 1;
    @(posedge clock); #1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rready", rready, 0);
    exp_pending = 0;
    m_id = 0;
    reset = 0;
    run(0, 32'h8000_0014, 0, 2, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 0);
    chk("abort_next_id", last_arid, 1);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
